// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding selects, load-use / branch-operand hazard
// detection and the stall/flush enables for the 5-stage pipeline, plus a
// small IDLE/BUSY controller that holds the pipeline while the multi-cycle
// divider in EX is working.
module hazard_unit #(
    parameter int REG_W      = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic             branch_D,
    input  logic [REG_W-1:0] rs_E,
    input  logic [REG_W-1:0] rt_E,
    input  logic [REG_W-1:0] writereg_E,
    input  logic             regwrite_E,
    input  logic             memtoreg_E,
    input  logic             div_start_E,
    input  logic [REG_W-1:0] writereg_M,
    input  logic             regwrite_M,
    input  logic             memtoreg_M,
    input  logic [REG_W-1:0] writereg_W,
    input  logic             regwrite_W,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             forwardA_D,
    output logic             forwardB_D,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_E,
    output logic             flush_M,
    output logic             div_busy,
    output logic             div_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } div_state_t;

    // Counter is 8 bits wide because DIV_CYCLES is limited to 1..255.
    localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

    div_state_t r_state;
    div_state_t w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    logic w_fwd_m_ok;
    logic w_fwd_w_ok;
    logic w_lw_stall;
    logic w_br_stall;
    logic w_div_stall;
    logic w_prod_e;
    logic w_prod_m;

    // EX operand select: MEM result wins over WB result; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel_e(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] wr_m,
        input logic             ok_m,
        input logic [REG_W-1:0] wr_w,
        input logic             ok_w
    );
        if (ok_m && (wr_m == src))      return 2'b10;
        else if (ok_w && (wr_w == src)) return 2'b01;
        else                            return 2'b00;
    endfunction

    assign w_fwd_m_ok = regwrite_M && (writereg_M != '0);
    assign w_fwd_w_ok = regwrite_W && (writereg_W != '0);

    assign forwardA_E = fwd_sel_e(rs_E, writereg_M, w_fwd_m_ok, writereg_W, w_fwd_w_ok);
    assign forwardB_E = fwd_sel_e(rt_E, writereg_M, w_fwd_m_ok, writereg_W, w_fwd_w_ok);
    assign forwardA_D = w_fwd_m_ok && (writereg_M == rs_D);
    assign forwardB_D = w_fwd_m_ok && (writereg_M == rt_D);

    // A load in EX cannot be forwarded to the instruction right behind it.
    assign w_lw_stall = memtoreg_E && (writereg_E != '0) &&
                        ((writereg_E == rs_D) || (writereg_E == rt_D));

    // Branch compares in ID: an EX producer or a MEM load is not ready yet.
    assign w_prod_e   = regwrite_E && (writereg_E != '0) &&
                        ((writereg_E == rs_D) || (writereg_E == rt_D));
    assign w_prod_m   = memtoreg_M && (writereg_M != '0) &&
                        ((writereg_M == rs_D) || (writereg_M == rt_D));
    assign w_br_stall = branch_D && (w_prod_e || w_prod_m);

    // Start is honoured only from IDLE; a held start while BUSY does not re-arm.
    assign w_div_stall = ((r_state == S_IDLE) && div_start_E) ||
                         ((r_state == S_BUSY) && (r_cnt != 8'd0));

    assign div_busy = (r_state == S_BUSY);
    assign div_done = (r_state == S_BUSY) && (r_cnt == 8'd0);

    assign stall_F = w_lw_stall || w_br_stall || w_div_stall;
    assign stall_D = stall_F;
    assign stall_E = w_div_stall;
    // Never inject a bubble over the divide being held in EX.
    assign flush_E = (w_lw_stall || w_br_stall) && !w_div_stall;
    // EX is frozen, so MEM must take a bubble instead of a duplicate.
    assign flush_M = w_div_stall;

    // Divider state and countdown register; reset aborts any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Divider next-state: load on start, count down, return to IDLE at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (div_start_E) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (DIV_CYCLES=4 and DIV_CYCLES=1) share
// one input bus; a reference model pushes expected outputs into per-instance
// queues and a negedge monitor pops and compares them.
module tb_hazard_unit;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs_D;
        logic [4:0] rt_D;
        logic       branch_D;
        logic [4:0] rs_E;
        logic [4:0] rt_E;
        logic [4:0] writereg_E;
        logic       regwrite_E;
        logic       memtoreg_E;
        logic       div_start_E;
        logic [4:0] writereg_M;
        logic       regwrite_M;
        logic       memtoreg_M;
        logic [4:0] writereg_W;
        logic       regwrite_W;
    } in_t;

    typedef struct packed {
        logic [1:0] fA_E;
        logic [1:0] fB_E;
        logic       fA_D;
        logic       fB_D;
        logic       stF;
        logic       stD;
        logic       stE;
        logic       flE;
        logic       flM;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur;
    exp_t act4, act1;
    exp_t q4[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    // Reference divider position: -1 = no divide, 1..D = cycles since start.
    int   k4 = -1;
    int   k1 = -1;

    hazard_unit #(.REG_W(5), .DIV_CYCLES(4)) dut4 (
        .clk(clk), .rst(cur.rst),
        .rs_D(cur.rs_D), .rt_D(cur.rt_D), .branch_D(cur.branch_D),
        .rs_E(cur.rs_E), .rt_E(cur.rt_E), .writereg_E(cur.writereg_E),
        .regwrite_E(cur.regwrite_E), .memtoreg_E(cur.memtoreg_E),
        .div_start_E(cur.div_start_E),
        .writereg_M(cur.writereg_M), .regwrite_M(cur.regwrite_M),
        .memtoreg_M(cur.memtoreg_M),
        .writereg_W(cur.writereg_W), .regwrite_W(cur.regwrite_W),
        .forwardA_E(act4.fA_E), .forwardB_E(act4.fB_E),
        .forwardA_D(act4.fA_D), .forwardB_D(act4.fB_D),
        .stall_F(act4.stF), .stall_D(act4.stD), .stall_E(act4.stE),
        .flush_E(act4.flE), .flush_M(act4.flM),
        .div_busy(act4.busy), .div_done(act4.done)
    );

    hazard_unit #(.REG_W(5), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .rst(cur.rst),
        .rs_D(cur.rs_D), .rt_D(cur.rt_D), .branch_D(cur.branch_D),
        .rs_E(cur.rs_E), .rt_E(cur.rt_E), .writereg_E(cur.writereg_E),
        .regwrite_E(cur.regwrite_E), .memtoreg_E(cur.memtoreg_E),
        .div_start_E(cur.div_start_E),
        .writereg_M(cur.writereg_M), .regwrite_M(cur.regwrite_M),
        .memtoreg_M(cur.memtoreg_M),
        .writereg_W(cur.writereg_W), .regwrite_W(cur.regwrite_W),
        .forwardA_E(act1.fA_E), .forwardB_E(act1.fB_E),
        .forwardA_D(act1.fA_D), .forwardB_D(act1.fB_D),
        .stall_F(act1.stF), .stall_D(act1.stD), .stall_E(act1.stE),
        .flush_E(act1.flE), .flush_M(act1.flM),
        .div_busy(act1.busy), .div_done(act1.done)
    );

    function automatic logic [1:0] ref_fwd(in_t x, logic [4:0] src);
        if (x.regwrite_M && x.writereg_M != 0 && x.writereg_M == src) return 2'b10;
        if (x.regwrite_W && x.writereg_W != 0 && x.writereg_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hits(logic [4:0] w, in_t x);
        return (w != 0) && (w == x.rs_D || w == x.rt_D);
    endfunction

    function automatic exp_t ref_model(in_t x, int k, int d);
        exp_t e;
        bit lw, br, dv;
        e      = '0;
        e.fA_E = ref_fwd(x, x.rs_E);
        e.fB_E = ref_fwd(x, x.rt_E);
        e.fA_D = x.regwrite_M && x.writereg_M != 0 && x.writereg_M == x.rs_D;
        e.fB_D = x.regwrite_M && x.writereg_M != 0 && x.writereg_M == x.rt_D;
        lw     = x.memtoreg_E && hits(x.writereg_E, x);
        br     = x.branch_D && ((x.regwrite_E && hits(x.writereg_E, x)) ||
                                (x.memtoreg_M && hits(x.writereg_M, x)));
        dv     = (k < 0 && x.div_start_E) || (k >= 1 && k < d);
        e.stF  = lw || br || dv;
        e.stD  = lw || br || dv;
        e.stE  = dv;
        e.flE  = (lw || br) && !dv;
        e.flM  = dv;
        e.busy = (k >= 1);
        e.done = (k == d);
        return e;
    endfunction

    function automatic int next_k(in_t x, int k, int d);
        if (x.rst)   return -1;
        if (k < 0)   return x.div_start_E ? 1 : -1;
        if (k < d)   return k + 1;
        return -1;
    endfunction

    task automatic chk(string name, int a, int e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, e, $time);
    endtask

    task automatic compare(string tag, exp_t a, exp_t e);
        chk({tag, ".forwardA_E"}, int'(a.fA_E), int'(e.fA_E));
        chk({tag, ".forwardB_E"}, int'(a.fB_E), int'(e.fB_E));
        chk({tag, ".forwardA_D"}, int'(a.fA_D), int'(e.fA_D));
        chk({tag, ".forwardB_D"}, int'(a.fB_D), int'(e.fB_D));
        chk({tag, ".stall_F"},    int'(a.stF),  int'(e.stF));
        chk({tag, ".stall_D"},    int'(a.stD),  int'(e.stD));
        chk({tag, ".stall_E"},    int'(a.stE),  int'(e.stE));
        chk({tag, ".flush_E"},    int'(a.flE),  int'(e.flE));
        chk({tag, ".flush_M"},    int'(a.flM),  int'(e.flM));
        chk({tag, ".div_busy"},   int'(a.busy), int'(e.busy));
        chk({tag, ".div_done"},   int'(a.done), int'(e.done));
    endtask

    // Drive one cycle of inputs and record what each instance must show.
    task automatic cycle(in_t x);
        @(posedge clk);
        #1;
        cur = x;
        q4.push_back(ref_model(x, k4, 4));
        q1.push_back(ref_model(x, k1, 1));
        k4 = next_k(x, k4, 4);
        k1 = next_k(x, k1, 1);
    endtask

    // Monitor: outputs are combinational, so one response per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                compare("D4", act4, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("D1", act1, e);
            end
        end
    end

    initial begin
        in_t x;
        x     = '0;
        x.rst = 1'b1;
        cur   = x;
        @(posedge clk);
        // Reset state with all inputs 0.
        cycle(x);
        x = '0;
        cycle(x);

        // Forwarding priority.
        x = '0; x.rs_E = 5; x.regwrite_M = 1; x.writereg_M = 5;
        x.regwrite_W = 1; x.writereg_W = 5;
        cycle(x);
        x.regwrite_M = 0;
        cycle(x);
        x.writereg_M = 0; x.writereg_W = 0;
        cycle(x);

        // Load-use.
        x = '0; x.memtoreg_E = 1; x.writereg_E = 8; x.rt_D = 8;
        cycle(x);
        x.writereg_E = 0;
        cycle(x);

        // Branch hazard, then producer moves to MEM as a non-load.
        x = '0; x.branch_D = 1; x.rs_D = 3; x.regwrite_E = 1; x.writereg_E = 3;
        cycle(x);
        x = '0; x.branch_D = 1; x.rs_D = 3; x.regwrite_M = 1; x.writereg_M = 3;
        cycle(x);

        // Divide with start held high.
        x = '0;
        cycle(x);
        x.div_start_E = 1;
        for (int i = 0; i < 5; i++) cycle(x);
        x = '0;
        for (int i = 0; i < 3; i++) cycle(x);

        // Divide plus load-use from cycle 2.
        x = '0; x.div_start_E = 1;
        cycle(x);
        cycle(x);
        x.memtoreg_E = 1; x.writereg_E = 8; x.rt_D = 8;
        for (int i = 0; i < 3; i++) cycle(x);
        x = '0;
        for (int i = 0; i < 3; i++) cycle(x);

        // Reset mid-divide.
        x = '0; x.div_start_E = 1;
        cycle(x);
        cycle(x);
        x.rst = 1;
        cycle(x);
        x = '0;
        cycle(x);
        cycle(x);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            x             = '0;
            x.rst         = ($urandom_range(0, 59) == 0);
            x.rs_D        = 5'($urandom_range(0, 3));
            x.rt_D        = 5'($urandom_range(0, 3));
            x.branch_D    = 1'($urandom_range(0, 1));
            x.rs_E        = 5'($urandom_range(0, 3));
            x.rt_E        = 5'($urandom_range(0, 3));
            x.writereg_E  = 5'($urandom_range(0, 3));
            x.regwrite_E  = 1'($urandom_range(0, 1));
            x.memtoreg_E  = 1'($urandom_range(0, 1));
            x.div_start_E = ($urandom_range(0, 5) == 0);
            x.writereg_M  = 5'($urandom_range(0, 3));
            x.regwrite_M  = 1'($urandom_range(0, 1));
            x.memtoreg_M  = 1'($urandom_range(0, 1));
            x.writereg_W  = 5'($urandom_range(0, 3));
            x.regwrite_W  = 1'($urandom_range(0, 1));
            cycle(x);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q4.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage CPU. It drives the select inputs of the operand-forwarding muxes in ID and EX, and the stall and flush enables of the pipeline registers. It detects load-use and branch-operand hazards. It also runs a small state machine that holds the pipeline while the multi-cycle divider in EX is busy. It sits beside the datapath and consumes register numbers and control bits from the ID, EX, MEM and WB stages.

## Interface
- `REG_W`, default 5: register-number width.
- `DIV_CYCLES`, default 32: number of stall cycles per divide. Legal range is 1..255.

- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rs_D`, `rt_D` input REG_W: source registers of the instruction in ID.
- `branch_D` input 1: the ID instruction is a branch that compares rs/rt in ID.
- `rs_E`, `rt_E` input REG_W: source registers of the instruction in EX.
- `writereg_E` input REG_W: destination register in EX.
- `regwrite_E` input 1: the EX instruction writes a register.
- `memtoreg_E` input 1: the EX instruction is a load.
- `div_start_E` input 1: the EX instruction is a divide.
- `writereg_M` input REG_W: destination register in MEM.
- `regwrite_M`, `memtoreg_M` input 1: register-write and load flags in MEM.
- `writereg_W` input REG_W: destination register in WB.
- `regwrite_W` input 1: register-write flag in WB.
- `forwardA_E`, `forwardB_E` output 2: EX operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `forwardA_D`, `forwardB_D` output 1: ID branch-compare operand select. 1 = MEM ALU result.
- `stall_F`, `stall_D`, `stall_E` output 1: hold the PC, IF/ID and ID/EX registers.
- `flush_E`, `flush_M` output 1: clear the ID/EX and EX/MEM registers. The cleared register is loaded with a bubble.
- `div_busy` output 1: the divider state machine is in BUSY.
- `div_done` output 1: one-cycle pulse on the last divide cycle.

Reset is synchronous and active-high on `rst`. There is a single clock, `clk`.

## Operation
- Forwarding is purely combinational and applies to both operands.
  - `forwardA_E` = 10 if `regwrite_M`, `writereg_M` ≠ 0 and `writereg_M` == `rs_E`.
  - Otherwise `forwardA_E` = 01 if `regwrite_W`, `writereg_W` ≠ 0 and `writereg_W` == `rs_E`.
  - Otherwise `forwardA_E` = 00.
  - MEM has priority over WB. `forwardB_E` uses the same rules with `rt_E`.
- `forwardA_D` = `regwrite_M` && `writereg_M` ≠ 0 && `writereg_M` == `rs_D`. `forwardB_D` uses the same rule with `rt_D`.
- Register 0 is never forwarded and never causes a stall.
- Load-use stall `lw_stall` = `memtoreg_E` && `writereg_E` ≠ 0 && (`writereg_E` == `rs_D` || `writereg_E` == `rt_D`).
- Branch stall `br_stall` = `branch_D` && (X || Y), where:
  - X = `regwrite_E` && `writereg_E` ≠ 0 && `writereg_E` matches `rs_D` or `rt_D`.
  - Y = `memtoreg_M` && `writereg_M` ≠ 0 && `writereg_M` matches `rs_D` or `rt_D`.
- The divider state machine has two states:
  - IDLE: when `div_start_E`=1, go to BUSY and load the counter with DIV_CYCLES-1.
  - BUSY: when the counter is not 0, decrement it. When the counter is 0, assert `div_done` and go to IDLE.
- `div_stall` = (IDLE && `div_start_E`) || (BUSY && counter ≠ 0).
- `div_start_E` is ignored while in BUSY. The divide instruction stays in EX during the stall, and the start is not re-armed.
- Output equations:
  - `stall_F` = `stall_D` = `lw_stall` || `br_stall` || `div_stall`.
  - `stall_E` = `div_stall`.
  - `flush_E` = (`lw_stall` || `br_stall`) && !`div_stall`. A bubble must never overwrite the divide held in EX.
  - `flush_M` = `div_stall`. This prevents the instruction ahead of the divide from being duplicated in MEM.
- `div_busy` = (state == BUSY).

## Timing
- All hazard, forward, stall and flush outputs are combinational from the inputs and the current state. There is zero-cycle latency.
- `rst` is sampled on the rising edge of `clk`. On reset the state becomes IDLE and the counter becomes 0.
  - `div_busy`=0 and `div_done`=0 after reset.
  - With all inputs 0, every output is 0.
  - A reset during BUSY aborts the divide with no `div_done` pulse.
- Divide sequence, starting from IDLE with `div_start_E`=1 at cycle 0:
  - The stall is asserted at cycles 0..DIV_CYCLES-1.
  - `div_done`=1 and the stall is low at cycle DIV_CYCLES.
  - The divide leaves EX at the edge that ends cycle DIV_CYCLES. The total time in EX is DIV_CYCLES+1 cycles.
- With DIV_CYCLES=1: BUSY is entered with the counter at 0, so `div_done` fires at cycle 1 after a single stall cycle.
- A load-use or branch hazard during a divide stall:
  - `stall_F` and `stall_D` remain high and `flush_E` stays 0.
  - The hazard is re-evaluated once the divide completes.

## Test plan
- Forwarding priority. Set `rs_E`=5, `regwrite_M`=1 with `writereg_M`=5, and `regwrite_W`=1 with `writereg_W`=5 → `forwardA_E`=10. Clear `regwrite_M` → `forwardA_E`=01. Set both write registers to 0 → `forwardA_E`=00.
- Load-use. Set `memtoreg_E`=1, `writereg_E`=8, `rt_D`=8 → `stall_F`=`stall_D`=`flush_E`=1 and `stall_E`=0. Change `writereg_E` to 0 → no stall.
- Branch hazard. Set `branch_D`=1, `rs_D`=3, `regwrite_E`=1, `writereg_E`=3 → stall and flush_E for one cycle. Then move the producer to MEM as a non-load → no stall and `forwardA_D`=1.
- Divide with DIV_CYCLES=4. Pulse `div_start_E` high while in IDLE and hold it high → `stall_E` and `flush_M` high for cycles 0–3, `div_done`=1 at cycle 4, `div_busy` high for cycles 1–4.
- Divide plus load-use. Assert `lw_stall` conditions during cycle 2 of a divide → `flush_E`=0 throughout while `stall_F`=1.
- Reset mid-divide. Assert `rst` at cycle 2 of a DIV_CYCLES=8 divide → the next cycle shows IDLE, `div_busy`=0, no `div_done` pulse, and all stalls low.
